// File: rtl/hci_mem_responder_if.sv
// hci_mem_responder_if: CPU byte-wide memory bus between CPU (master) and responder (slave)
interface hci_mem_responder_if;
  logic        mem_ce_in;
  logic        mem_wr_in;
  logic [31:0] mem_addr_in;
  logic [7:0]  mem_data_in;
  logic [7:0]  mem_data_o;
  logic        rdy_o;
  modport slave (input mem_ce_in, mem_wr_in, mem_addr_in, mem_data_in, output mem_data_o, rdy_o);
  modport master(output mem_ce_in, mem_wr_in, mem_addr_in, mem_data_in, input mem_data_o, rdy_o);
endinterface

// File: rtl/hci_mem_responder.sv
// hci_mem_responder: CPU bus target with byte RAM, UART RX/TX FIFOs, cycle counter and halt flag
module hci_mem_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int RX_DEPTH_LOG2  = 3,
  parameter int TX_DEPTH_LOG2  = 3
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  hci_mem_responder_if.slave  bus,
  input  logic [7:0]          rx_byte_i,
  input  logic                rx_valid_i,
  output logic                rx_overflow_o,
  output logic [7:0]          tx_byte_o,
  output logic                tx_valid_o,
  input  logic                tx_ready_i,
  output logic                halt_o
);
  localparam int RXD = 1 << RX_DEPTH_LOG2;
  localparam int TXD = 1 << TX_DEPTH_LOG2;
  logic [7:0] ram [2**RAM_ADDR_WIDTH];
  logic [7:0] rx_mem [RXD];
  logic [7:0] tx_mem [TXD];
  logic [RX_DEPTH_LOG2-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [RX_DEPTH_LOG2:0]   rx_cnt_q, rx_cnt_d;
  logic [TX_DEPTH_LOG2-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [TX_DEPTH_LOG2:0]   tx_cnt_q, tx_cnt_d;
  logic [31:0] cyc_q, cyc_d, snap_q, snap_d;
  logic [7:0]  rdata_q, rdata_d, tx_byte_q, tx_byte_d, tx_wdata, io_rdata;
  logic        tx_valid_q, tx_valid_d, halt_q, halt_d, ovf_q, ovf_d;
  logic        acc, rd, wr, is_ram, is_io, rx_push, rx_pop, tx_push, tx_pop;
  logic [2:0]  off;
  logic [RAM_ADDR_WIDTH-1:0] ram_a;
  logic [13:0] unused_addr;
  assign unused_addr = bus.mem_addr_in[31:18];
  // Count MSB set means exactly full since the count never exceeds the depth
  assign bus.rdy_o = rst_n_in & ~tx_cnt_q[TX_DEPTH_LOG2];
  assign acc    = bus.mem_ce_in & bus.rdy_o;
  assign rd     = acc & ~bus.mem_wr_in;
  assign wr     = acc & bus.mem_wr_in;
  assign is_ram = ~bus.mem_addr_in[17];
  assign is_io  = &bus.mem_addr_in[17:16];
  assign off    = bus.mem_addr_in[2:0];
  assign ram_a  = bus.mem_addr_in[RAM_ADDR_WIDTH-1:0];
  assign rx_pop   = rd & is_io & (off == 3'd0) & (|rx_cnt_q);
  assign rx_push  = rx_valid_i & (~rx_cnt_q[RX_DEPTH_LOG2] | rx_pop);
  assign tx_pop   = tx_valid_q & tx_ready_i;
  assign tx_push  = wr & is_io & (((off == 3'd0) & (|bus.mem_data_in)) | (off == 3'd4));
  assign tx_wdata = off[2] ? 8'h00 : bus.mem_data_in;
  always_comb begin
    io_rdata = off == 3'd0 ? (|rx_cnt_q ? rx_mem[rx_rp_q] : 8'h00) :
               off == 3'd4 ? cyc_q[7:0] :
               off == 3'd5 ? snap_q[15:8] :
               off == 3'd6 ? snap_q[23:16] :
               off == 3'd7 ? snap_q[31:24] : 8'h00;
    rdata_d  = ~rd ? rdata_q : is_ram ? ram[ram_a] : is_io ? io_rdata : 8'h00;
    snap_d   = (rd & is_io & (off == 3'd4)) ? cyc_q : snap_q;
    cyc_d    = cyc_q + 32'd1;
    halt_d   = halt_q | (wr & is_io & (off == 3'd4));
    ovf_d    = ovf_q | (rx_valid_i & rx_cnt_q[RX_DEPTH_LOG2] & ~rx_pop);
    rx_wp_d  = rx_wp_q + RX_DEPTH_LOG2'(rx_push);
    rx_rp_d  = rx_rp_q + RX_DEPTH_LOG2'(rx_pop);
    rx_cnt_d = rx_cnt_q + (RX_DEPTH_LOG2+1)'(rx_push) - (RX_DEPTH_LOG2+1)'(rx_pop);
    tx_wp_d  = tx_wp_q + TX_DEPTH_LOG2'(tx_push);
    tx_rp_d  = tx_rp_q + TX_DEPTH_LOG2'(tx_pop);
    tx_cnt_d = tx_cnt_q + (TX_DEPTH_LOG2+1)'(tx_push) - (TX_DEPTH_LOG2+1)'(tx_pop);
    tx_valid_d = |tx_cnt_d;
    // A byte pushed into a FIFO that is empty after this edge's pop becomes the head directly
    tx_byte_d  = ~|tx_cnt_d ? 8'h00 :
                 (tx_cnt_q == (TX_DEPTH_LOG2+1)'(tx_pop)) ? tx_wdata : tx_mem[tx_rp_d];
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cyc_q      <= '0;
      snap_q     <= '0;
      rdata_q    <= '0;
      halt_q     <= 1'b0;
      ovf_q      <= 1'b0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      rx_cnt_q   <= '0;
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      tx_cnt_q   <= '0;
      tx_valid_q <= 1'b0;
      tx_byte_q  <= '0;
    end else begin
      cyc_q      <= cyc_d;
      snap_q     <= snap_d;
      rdata_q    <= rdata_d;
      halt_q     <= halt_d;
      ovf_q      <= ovf_d;
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_byte_q  <= tx_byte_d;
    end
  end
  always_ff @(posedge clk_in) begin
    if (wr & is_ram) ram[ram_a] <= bus.mem_data_in;
    if (rx_push) rx_mem[rx_wp_q] <= rx_byte_i;
    if (tx_push) tx_mem[tx_wp_q] <= tx_wdata;
  end
  assign bus.mem_data_o = rdata_q;
  assign tx_byte_o      = tx_byte_q;
  assign tx_valid_o     = tx_valid_q;
  assign rx_overflow_o  = ovf_q;
  assign halt_o         = halt_q;
endmodule

// File: tb/tb_hci_mem_responder.sv
// tb_hci_mem_responder: directed self-checking bench for hci_mem_responder
module tb_hci_mem_responder;
  logic clk_in = 1'b0;
  logic rst_n_in = 1'b1;
  logic [7:0] rx_byte_i = '0;
  logic rx_valid_i = 1'b0;
  logic rx_overflow_o;
  logic [7:0] tx_byte_o;
  logic tx_valid_o;
  logic tx_ready_i = 1'b0;
  logic halt_o;
  int n_chk = 0;
  int n_err = 0;
  logic [31:0] cyc_m;
  logic [7:0] txq[$];
  hci_mem_responder_if bus();
  hci_mem_responder dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .bus(bus),
    .rx_byte_i(rx_byte_i), .rx_valid_i(rx_valid_i), .rx_overflow_o(rx_overflow_o),
    .tx_byte_o(tx_byte_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i), .halt_o(halt_o)
  );
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in or negedge rst_n_in) cyc_m <= !rst_n_in ? 32'd0 : cyc_m + 32'd1;
  always @(negedge clk_in) if (tx_valid_o && tx_ready_i) txq.push_back(tx_byte_o);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask
  task automatic bus_acc(input logic w, input logic [31:0] a, input logic [7:0] d);
    bus.mem_ce_in = 1'b1;
    bus.mem_wr_in = w;
    bus.mem_addr_in = a;
    bus.mem_data_in = d;
    step();
    bus.mem_ce_in = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.mem_ce_in = 1'b0;
    bus.mem_wr_in = 1'b0;
    bus.mem_addr_in = '0;
    bus.mem_data_in = '0;
    #1 rst_n_in = 1'b0;
    #2;
    chk("rst_rdata", bus.mem_data_o, 8'h00);
    chk("rst_rdy", bus.rdy_o, 1'b0);
    chk("rst_tx_valid", tx_valid_o, 1'b0);
    chk("rst_tx_byte", tx_byte_o, 8'h00);
    chk("rst_ovf", rx_overflow_o, 1'b0);
    chk("rst_halt", halt_o, 1'b0);
    step();
    step();
    rst_n_in = 1'b1;
    #1;
    chk("rdy_after_release", bus.rdy_o, 1'b1);
    // RAM and unmapped region
    bus_acc(1'b1, 32'h0001_2345, 8'hA5);
    bus_acc(1'b1, 32'h0000_0000, 8'h3C);
    bus_acc(1'b0, 32'h0001_2345, 8'h00);
    chk("ram_rd_a5", bus.mem_data_o, 8'hA5);
    bus_acc(1'b1, 32'h0000_0001, 8'h99);
    chk("rdata_hold_wr", bus.mem_data_o, 8'hA5);
    step();
    chk("rdata_hold_idle", bus.mem_data_o, 8'hA5);
    bus_acc(1'b0, 32'h0002_0000, 8'h00);
    chk("unmapped_rd", bus.mem_data_o, 8'h00);
    bus_acc(1'b1, 32'h0002_0000, 8'h77);
    bus_acc(1'b0, 32'h0000_0000, 8'h00);
    chk("ram_rd_3c", bus.mem_data_o, 8'h3C);
    bus_acc(1'b0, 32'hFFFC_0001, 8'h00);
    chk("ram_rd_hi_ignored", bus.mem_data_o, 8'h99);
    // Cycle counter snapshot
    for (int i = 0; i < 1000 && cyc_m != 32'h1F3; i++) step();
    chk("cnt_reached", cyc_m, 32'h1F3);
    bus_acc(1'b0, 32'h0003_0004, 8'h00);
    chk("cnt_b0", bus.mem_data_o, 8'hF3);
    repeat (5) step();
    bus_acc(1'b0, 32'h0003_0005, 8'h00);
    chk("cnt_b1", bus.mem_data_o, 8'h01);
    bus_acc(1'b0, 32'h0003_0006, 8'h00);
    chk("cnt_b2", bus.mem_data_o, 8'h00);
    bus_acc(1'b0, 32'h0003_0007, 8'h00);
    chk("cnt_b3", bus.mem_data_o, 8'h00);
    bus_acc(1'b0, 32'h0003_0002, 8'h00);
    chk("io_other_rd", bus.mem_data_o, 8'h00);
    // TX basic: zero byte is dropped
    tx_ready_i = 1'b1;
    txq.delete();
    bus_acc(1'b1, 32'h0003_0000, 8'h41);
    bus_acc(1'b1, 32'h0003_0000, 8'h00);
    bus_acc(1'b1, 32'h0003_0000, 8'h42);
    repeat (4) step();
    chk("tx_seq_len", txq.size(), 2);
    chk("tx_seq0", txq.size() > 0 ? txq[0] : 8'hxx, 8'h41);
    chk("tx_seq1", txq.size() > 1 ? txq[1] : 8'hxx, 8'h42);
    chk("tx_idle_valid", tx_valid_o, 1'b0);
    // TX full backpressure
    tx_ready_i = 1'b0;
    txq.delete();
    for (int i = 0; i < 8; i++) begin
      chk("tx_fill_rdy", bus.rdy_o, 1'b1);
      bus_acc(1'b1, 32'h0003_0000, 8'h55);
    end
    chk("tx_full_rdy", bus.rdy_o, 1'b0);
    chk("tx_full_valid", tx_valid_o, 1'b1);
    bus.mem_ce_in = 1'b1;
    bus.mem_wr_in = 1'b1;
    bus.mem_addr_in = 32'h0003_0000;
    bus.mem_data_in = 8'h66;
    repeat (3) step();
    chk("tx_frozen_rdy", bus.rdy_o, 1'b0);
    tx_ready_i = 1'b1;
    step();
    tx_ready_i = 1'b0;
    chk("rdy_after_pop", bus.rdy_o, 1'b1);
    step();
    chk("rdy_after_push", bus.rdy_o, 1'b0);
    bus.mem_ce_in = 1'b0;
    tx_ready_i = 1'b1;
    repeat (12) step();
    tx_ready_i = 1'b0;
    chk("tx_drain_len", txq.size(), 9);
    chk("tx_drain0", txq.size() > 0 ? txq[0] : 8'hxx, 8'h55);
    chk("tx_drain7", txq.size() > 7 ? txq[7] : 8'hxx, 8'h55);
    chk("tx_drain8", txq.size() > 8 ? txq[8] : 8'hxx, 8'h66);
    chk("tx_drain_valid", tx_valid_o, 1'b0);
    chk("tx_drain_rdy", bus.rdy_o, 1'b1);
    // RX FIFO
    rx_byte_i = 8'h10; rx_valid_i = 1'b1; step();
    rx_byte_i = 8'h20; step();
    rx_valid_i = 1'b0;
    bus_acc(1'b0, 32'h0003_0000, 8'h00);
    chk("rx_rd0", bus.mem_data_o, 8'h10);
    bus_acc(1'b0, 32'h0003_0000, 8'h00);
    chk("rx_rd1", bus.mem_data_o, 8'h20);
    bus_acc(1'b0, 32'h0003_0000, 8'h00);
    chk("rx_rd_empty", bus.mem_data_o, 8'h00);
    rx_byte_i = 8'h33; rx_valid_i = 1'b1;
    bus_acc(1'b0, 32'h0003_0000, 8'h00);
    rx_valid_i = 1'b0;
    chk("rx_empty_pushpop", bus.mem_data_o, 8'h00);
    bus_acc(1'b0, 32'h0003_0000, 8'h00);
    chk("rx_empty_pushpop_kept", bus.mem_data_o, 8'h33);
    for (int i = 0; i < 9; i++) begin
      rx_byte_i = 8'h80 + 8'(i);
      rx_valid_i = 1'b1;
      step();
      if (i == 7) chk("rx_ovf_at_full", rx_overflow_o, 1'b0);
    end
    rx_valid_i = 1'b0;
    chk("rx_ovf_set", rx_overflow_o, 1'b1);
    rx_byte_i = 8'h99; rx_valid_i = 1'b1;
    bus_acc(1'b0, 32'h0003_0000, 8'h00);
    rx_valid_i = 1'b0;
    chk("rx_full_pushpop", bus.mem_data_o, 8'h80);
    for (int i = 1; i < 8; i++) begin
      bus_acc(1'b0, 32'h0003_0000, 8'h00);
      chk("rx_drain", bus.mem_data_o, 8'h80 + 32'(i));
    end
    bus_acc(1'b0, 32'h0003_0000, 8'h00);
    chk("rx_drain_99", bus.mem_data_o, 8'h99);
    bus_acc(1'b0, 32'h0003_0000, 8'h00);
    chk("rx_drain_empty", bus.mem_data_o, 8'h00);
    chk("rx_ovf_sticky", rx_overflow_o, 1'b1);
    // Halt and reset mid-stream
    txq.delete();
    bus_acc(1'b1, 32'h0003_0004, 8'hFF);
    chk("halt_set", halt_o, 1'b1);
    chk("halt_tx_valid", tx_valid_o, 1'b1);
    chk("halt_tx_byte", tx_byte_o, 8'h00);
    bus_acc(1'b1, 32'h0000_0100, 8'h5A);
    bus_acc(1'b0, 32'h0000_0100, 8'h00);
    chk("halt_no_block", bus.mem_data_o, 8'h5A);
    chk("halt_sticky", halt_o, 1'b1);
    #2;
    bus.mem_ce_in = 1'b1;
    bus.mem_wr_in = 1'b1;
    bus.mem_addr_in = 32'h0001_2345;
    bus.mem_data_in = 8'h11;
    rst_n_in = 1'b0;
    #1;
    chk("mrst_halt", halt_o, 1'b0);
    chk("mrst_tx_valid", tx_valid_o, 1'b0);
    chk("mrst_tx_byte", tx_byte_o, 8'h00);
    chk("mrst_rdata", bus.mem_data_o, 8'h00);
    chk("mrst_rdy", bus.rdy_o, 1'b0);
    chk("mrst_ovf", rx_overflow_o, 1'b0);
    step();
    step();
    bus.mem_ce_in = 1'b0;
    rst_n_in = 1'b1;
    #1;
    chk("mrst_rdy_release", bus.rdy_o, 1'b1);
    bus_acc(1'b0, 32'h0001_2345, 8'h00);
    chk("mrst_ram_kept", bus.mem_data_o, 8'hA5);
    bus_acc(1'b0, 32'h0003_0000, 8'h00);
    chk("mrst_rx_empty", bus.mem_data_o, 8'h00);
    chk("mrst_tx_empty", tx_valid_o, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/hci_mem_responder.md
Name: hci_mem_responder

Overview:
- Memory/IO responder on the CPU's byte-wide memory bus; the target end of the CPU's mem_addr/mem_dout/mem_wr/mem_din/rdy_in interface.
- Contains 128 KB byte RAM, a UART-facing RX FIFO, a TX FIFO, a 32-bit cycle counter and a halt flag.
- Decodes IO at mem_addr[17:16]==2'b11.
- Generates the CPU's rdy_in so the CPU freezes while the TX path is full.

Parameters:
RAM_ADDR_WIDTH, 17, RAM byte address width (2^17 bytes)
RX_DEPTH_LOG2, 3, RX FIFO depth = 2^3 entries
TX_DEPTH_LOG2, 3, TX FIFO depth = 2^3 entries

Ports:
clk_in  in  1  clock
rst_n_in  in  1  asynchronous reset, active low
mem_ce_in  in  1  access strobe from CPU; access only when high
mem_wr_in  in  1  1=write, 0=read
mem_addr_in  in  32  byte address; only [17:0] decoded
mem_data_in  in  8  write byte from CPU (CPU mem_dout)
mem_data_o  out  8  read byte to CPU (CPU mem_din)
rdy_o  out  1  to CPU rdy_in; low = CPU must freeze
rx_byte_i  in  8  received UART byte
rx_valid_i  in  1  push rx_byte_i into RX FIFO
rx_overflow_o  out  1  sticky: push attempted while RX FIFO full
tx_byte_o  out  8  TX FIFO head
tx_valid_o  out  1  TX FIFO non-empty
tx_ready_i  in  1  UART consumes head when tx_valid_o & tx_ready_i
halt_o  out  1  sticky program-stop flag

Behaviour:
- Reset (rst_n_in low, async): mem_data_o=0, rdy_o=0, tx_valid_o=0, tx_byte_o=0, rx_overflow_o=0, halt_o=0, both FIFOs empty, counter=0, snapshot=0. RAM contents are not cleared. Reset mid-access aborts the access with no side effect.
- rdy_o = reset released & TX FIFO not full. It is combinational from the registered count.
- Access accepted: rising edge with mem_ce_in & rdy_o. All accesses are ignored while rdy_o is low, so a frozen CPU holding its bus never repeats side effects.
- Read latency: a read accepted at edge N drives mem_data_o from edge N (visible cycle N+1). mem_data_o holds its value on writes and idle cycles.
- Write latency: 0 wait; takes effect at the accepting edge.
- Decode (addr[17:16]):
  - 00/01: RAM[addr[16:0]].
  - 10: unmapped; read returns 0x00, write ignored.
  - 11: IO, by addr[2:0]:
    - 0x0 read: pop RX head. If RX is empty, return 0x00 with no pop.
    - 0x0 write: push byte to TX. Byte 0x00 is ignored, no push.
    - 0x4 read: snapshot <= counter; return counter[7:0] in the same edge.
    - 0x5/0x6/0x7 read: return snapshot[15:8]/[23:16]/[31:24]. Little-endian dword.
    - 0x4 write: halt_o <= 1 (sticky until reset) and push 0x00 to TX regardless of data.
    - Other IO offsets: read 0x00, write ignored.
- Counter: 32-bit, +1 every cycle after reset, including when rdy_o is low or halted. Wraps 0xFFFFFFFF -> 0.
- RX FIFO:
  - Push on rx_valid_i when not full. When full, drop the byte and set rx_overflow_o.
  - Simultaneous push and pop on a full FIFO: the pop frees a slot and the push succeeds.
  - Simultaneous push and pop on an empty FIFO: the read returns 0x00 and the pushed byte is stored.
- TX FIFO:
  - Pop when tx_valid_o & tx_ready_i. tx_byte_o/tx_valid_o are registered from FIFO state.
  - Push from the CPU is only possible when not full, guaranteed by rdy_o.
  - Simultaneous push and pop keeps the count unchanged.
- Pointers are RX_DEPTH_LOG2/TX_DEPTH_LOG2 bits wide with wrap-around. Full/empty come from a separate count register (width log2+1).
- halt_o does not block further accesses.

Test Plan:
- Write 0xA5 to 0x00012345, then read 0x00012345 -> mem_data_o=0xA5 one cycle after the accepting edge; reading 0x00020000 -> 0x00.
- Write 0x41 then 0x00 then 0x42 to 0x30000, tx_ready_i=1 -> tx_byte_o sequence 0x41, 0x42 only; tx_valid_o then drops.
- tx_ready_i=0, 8 writes of 0x55 to 0x30000 -> rdy_o low after the 8th. A 9th write held on the bus is not pushed. Raising tx_ready_i for 1 cycle -> rdy_o high and exactly one more push on acceptance.
- Push 0x10, 0x20 via rx_valid_i; read 0x30000 three times -> 0x10, 0x20, 0x00. Then 9 pushes -> rx_overflow_o=1, 8 bytes retained.
- Read 0x30004 at counter 0x000001F3, advance 5 cycles, read 0x30005..0x30007 -> 0xF3, 0x01, 0x00, 0x00.
- Write 0x30004 -> halt_o=1 and a 0x00 byte appears on tx_byte_o. Assert rst_n_in low mid-stream -> all outputs at reset values immediately, halt_o=0, FIFOs empty.
